count_0_stream: RTL and testbench

Streaming, multi-channel successor to the combinational zero counter. It accepts beats of CHANNELS x WIDTH bits over a valid/ready handshake. It counts zero bits (or one bits, per a mode selected once per frame) across all channels of each beat, and accumulates the count over a frame terminated by i_last. It then presents the saturated frame total with a sticky overflow flag on an output valid/ready handshake.

---
 rtl/count_0_stream.sv | 135 +++++++++++++
 tb/tb_count_0_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_0_stream.sv
// Streaming multi-channel zero/one bit counter: accumulates per-beat popcounts
// over a frame and hands out a saturated total with a sticky overflow flag.
module count_0_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_BITS = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic                      i_mode,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic                      i_valid,
  input  logic                      i_last,
  output logic                      o_in_ready,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [CNT_BITS-1:0]       o_count,
  output logic                      o_overflow
);

  localparam int NB = CHANNELS * WIDTH;
  localparam int PW = $clog2(NB + 1);
  localparam int SW = ((CNT_BITS > PW) ? CNT_BITS : PW) + 1;
  localparam logic [CNT_BITS-1:0] MAX = {CNT_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                mode_q, mode_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                oovf_q, oovf_d;

  logic                accept;
  logic                eff_mode;
  logic [NB-1:0]       beat_bits;
  logic [PW-1:0]       beat_cnt;
  logic [CNT_BITS-1:0] base;
  logic [SW-1:0]       sum_ext;
  logic                sat;
  logic [CNT_BITS-1:0] acc_new;
  logic                ovf_new;

  assign accept = i_valid & o_in_ready;

  // First beat of a frame uses the live mode; later beats use the latched one.
  always_comb begin
    eff_mode  = (state_q == IDLE) ? i_mode : mode_q;
    beat_bits = eff_mode ? i_data : ~i_data;
    beat_cnt  = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      for (int b = 0; b < WIDTH; b++) begin
        beat_cnt = beat_cnt + PW'(beat_bits[ch*WIDTH+b]);
      end
    end
  end

  always_comb begin
    base    = (state_q == IDLE) ? '0 : acc_q;
    sum_ext = SW'(base) + SW'(beat_cnt);
    sat     = (sum_ext > SW'(MAX));
    acc_new = sat ? MAX : sum_ext[CNT_BITS-1:0];
    ovf_new = ((state_q == IDLE) ? 1'b0 : ovf_q) | sat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
      count_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      oovf_q  <= oovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = i_last ? DONE : ACC;
        ACC:     if (accept && i_last) state_d = DONE;
        DONE:    if (i_out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath updates; the published result only changes on a frame's last beat.
  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    count_d = count_q;
    oovf_d  = oovf_q;
    if (i_flush) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      acc_d = acc_new;
      ovf_d = ovf_new;
      if (state_q == IDLE) mode_d = i_mode;
      if (i_last) begin
        count_d = acc_new;
        oovf_d  = ovf_new;
      end
    end else if (state_q == DONE && i_out_ready) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    o_in_ready  = (state_q != DONE);
    o_out_valid = (state_q == DONE);
    o_count     = count_q;
    o_overflow  = oovf_q;
  end

endmodule

// File: tb/tb_count_0_stream.sv
// Self-checking bench for count_0_stream: vector table, directed corner cases
// and randomized frames against a frame-level popcount model.
module tb_count_0_stream;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_mode = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        o_in_ready;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [7:0]  o_count;
  logic        o_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  count_0_stream dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_flush    (i_flush),
    .i_mode     (i_mode),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .o_in_ready (o_in_ready),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        mode;
    logic [31:0] data;
    int          exp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int pc(input logic [31:0] d, input logic m);
    logic [31:0] inv;
    inv = ~d;
    return m ? $countones(d) : $countones(inv);
  endfunction

  // Drive one beat; inputs change #1 after a rising edge, so sampling is safe.
  task automatic beat(input logic [31:0] d, input logic m, input logic l);
    chk("in_ready_before_beat", int'(o_in_ready), 1);
    i_data  = d;
    i_mode  = m;
    i_last  = l;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = $urandom;
    i_mode  = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic result(input string name, input int total);
    int ec;
    int eo;
    ec = (total > 255) ? 255 : total;
    eo = (total > 255) ? 1 : 0;
    chk({name, "_valid"}, int'(o_out_valid), 1);
    chk({name, "_count"}, int'(o_count), ec);
    chk({name, "_ovf"}, int'(o_overflow), eo);
    chk({name, "_in_ready"}, int'(o_in_ready), 0);
    $display("frame %s: count=%0d ovf=%0d (model total %0d)", name, o_count, o_overflow, total);
  endtask

  task automatic consume();
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_out_ready = 1'b0;
    chk("post_consume_valid", int'(o_out_valid), 0);
    chk("post_consume_in_ready", int'(o_in_ready), 1);
  endtask

  // Flush with a beat presented in the same cycle; that beat must be lost.
  task automatic flush_with_beat();
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_data  = 32'h0000_0000;
    i_mode  = 1'b0;
    i_last  = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk("flush_valid", int'(o_out_valid), 0);
    chk("flush_in_ready", int'(o_in_ready), 1);
  endtask

  initial begin
    logic [7:0] held;
    int         total;
    int         len;
    logic       fm;
    logic [31:0] d;

    tbl[0] = '{1'b0, 32'h0000_0000, 32};
    tbl[1] = '{1'b1, 32'h0000_0000, 0};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF, 0};
    tbl[3] = '{1'b1, 32'hFFFF_FF00, 24};
    tbl[4] = '{1'b0, 32'hFFFF_FF00, 8};
    tbl[5] = '{1'b1, 32'h0F0F_0F0F, 16};
    tbl[6] = '{1'b1, 32'h0000_0001, 1};

    #2;
    chk("reset_valid", int'(o_out_valid), 0);
    chk("reset_count", int'(o_count), 0);
    chk("reset_ovf", int'(o_overflow), 0);
    chk("reset_in_ready", int'(o_in_ready), 1);
    #20 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int t = 0; t < 7; t++) begin
      beat(tbl[t].data, tbl[t].mode, 1'b1);
      result($sformatf("tbl%0d", t), tbl[t].exp);
      consume();
    end

    // Multi-beat frame with an input gap; ACC keeps waiting and stays ready.
    beat(32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(2);
    chk("gap_valid", int'(o_out_valid), 0);
    chk("gap_in_ready", int'(o_in_ready), 1);
    beat(32'h0F0F_0F0F, 1'b1, 1'b0);
    beat(32'h0000_00FF, 1'b1, 1'b1);
    result("gap", 40);
    consume();

    for (int b = 0; b < 8; b++) beat(32'hFFFF_FFFF, 1'b1, b == 7);
    result("saturate", 256);
    consume();
    beat(32'hFFFF_FF00, 1'b0, 1'b1);
    result("ovf_cleared", 8);
    consume();

    beat(32'h0000_000F, 1'b1, 1'b0);
    beat(32'h0000_000F, 1'b0, 1'b1);
    result("mode_latched", 8);

    // Backpressure with beats offered: nothing may move.
    held = o_count;
    i_valid = 1'b1;
    i_data  = 32'h0000_0000;
    i_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      chk("bp_valid", int'(o_out_valid), 1);
      chk("bp_count", int'(o_count), int'(held));
      chk("bp_in_ready", int'(o_in_ready), 0);
    end
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_out_ready = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk("bp_release_valid", int'(o_out_valid), 0);
    chk("bp_release_in_ready", int'(o_in_ready), 1);
    chk("bp_count_held", int'(o_count), 8);
    beat(32'h0000_0003, 1'b1, 1'b1);
    result("after_bp", 2);
    consume();

    beat(32'h0000_0000, 1'b0, 1'b0);
    beat(32'h0000_0000, 1'b0, 1'b0);
    flush_with_beat();
    beat(32'h0000_0000, 1'b0, 1'b1);
    result("after_flush", 32);
    consume();

    beat(32'hFFFF_FFFF, 1'b1, 1'b0);
    beat(32'hFFFF_FFFF, 1'b1, 1'b0);
    #3 i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(o_out_valid), 0);
    chk("async_rst_count", int'(o_count), 0);
    chk("async_rst_ovf", int'(o_overflow), 0);
    #2 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("rst_release_in_ready", int'(o_in_ready), 1);
    beat(32'hFFFF_FFFF, 1'b1, 1'b1);
    result("after_rst", 32);
    consume();

    // Randomized frames against the frame-level model.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) beat($urandom, 1'($urandom), 1'b0);
        flush_with_beat();
      end
      len   = $urandom_range(1, 12);
      fm    = 1'($urandom);
      total = 0;
      for (int b = 0; b < len; b++) begin
        idle($urandom_range(0, 2));
        d = $urandom;
        if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) d = 32'h0000_0000;
        total += pc(d, fm);
        beat(d, (b == 0) ? fm : 1'($urandom), b == len - 1);
      end
      result($sformatf("rnd%0d", f), total);
      held = o_count;
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        @(posedge i_clk); #1;
        chk("rnd_bp_valid", int'(o_out_valid), 1);
        chk("rnd_bp_count", int'(o_count), int'(held));
      end
      consume();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
